rom_read_arbiter: RTL

Round-robin arbiter that shares one single-port synchronous ROM between p_NUM_REQ requesters. The ROM has 1-cycle read latency and outputs zero when not enabled.
- Each grant is a locked burst of sequential reads with address auto-increment and wrap.
- Returned data is steered back with a one-hot valid and a last-beat flag.
- Sits between client blocks (sequencers, table lookups) and the ROM instance.

---
 rtl/rom_read_arbiter_pkg.sv | 15 +
 rtl/rr_priority_picker.sv | 41 ++++
 rtl/rom_read_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/rom_read_arbiter_pkg.sv
// Shared types and helpers for the round-robin ROM read arbiter.
// The state encoding is fixed so that IDLE is 1'b0 and BURST is 1'b1.
package rom_read_arbiter_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  // Width of a requester index; never less than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker. It returns the first request bit found
// when searching upward from ptr+1, wrapping modulo p_NUM_REQ.
module rr_priority_picker
  import rom_read_arbiter_pkg::*;
#(
  parameter int p_NUM_REQ   = 4,
  parameter int p_IDX_WIDTH = idx_width(p_NUM_REQ)
) (
  input  logic [p_NUM_REQ-1:0]   req,
  input  logic [p_IDX_WIDTH-1:0] ptr,
  output logic [p_NUM_REQ-1:0]   winner,
  output logic [p_IDX_WIDTH-1:0] winner_idx,
  output logic                   found
);

  // cand[k] holds the requester index that has priority rank k.
  logic [p_IDX_WIDTH-1:0] cand [p_NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < p_NUM_REQ; gi++) begin : g_cand
      assign cand[gi] = p_IDX_WIDTH'((int'(ptr) + gi + 1) % p_NUM_REQ);
    end
  endgenerate

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    for (int k = 0; k < p_NUM_REQ; k++) begin
      if (!found && req[cand[k]]) begin
        found      = 1'b1;
        winner_idx = cand[k];
      end
    end
    if (found) begin
      winner[winner_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one single-port synchronous ROM (1-cycle latency) among several
// requesters; each grant is a locked burst of sequential, wrapping reads.
module rom_read_arbiter
  import rom_read_arbiter_pkg::*;
#(
  parameter int p_NUM_REQ    = 4,
  parameter int p_ADDR_WIDTH = 4,
  parameter int p_DATA_WIDTH = 8,
  parameter int p_LEN_WIDTH  = 3
) (
  input  logic                              i_CLK,
  input  logic                              i_RESET,
  input  logic [p_NUM_REQ-1:0]              i_REQ,
  input  logic [p_NUM_REQ*p_ADDR_WIDTH-1:0] i_ADDR,
  input  logic [p_NUM_REQ*p_LEN_WIDTH-1:0]  i_LEN,
  output logic [p_NUM_REQ-1:0]              o_GRANT,
  output logic                              o_BUSY,
  output logic [p_NUM_REQ-1:0]              o_VALID,
  output logic                              o_LAST,
  output logic [p_DATA_WIDTH-1:0]           o_DATA,
  output logic                              o_ROM_READ_ENABLE,
  output logic [p_ADDR_WIDTH-1:0]           o_ROM_ADDRESS,
  input  logic [p_DATA_WIDTH-1:0]           i_ROM_DATA
);

  localparam int IW = idx_width(p_NUM_REQ);

  state_t                  state_reg, state_next;
  logic [IW-1:0]           ptr_reg;
  logic [IW-1:0]           owner_reg;
  logic [p_ADDR_WIDTH-1:0] addr_reg;
  logic [p_LEN_WIDTH-1:0]  cnt_reg;
  logic [p_NUM_REQ-1:0]    valid_reg;
  logic                    last_reg;

  logic [p_NUM_REQ-1:0]    pick_onehot;
  logic [IW-1:0]           pick_idx;
  logic                    pick_found;
  logic                    accept;

  logic [p_ADDR_WIDTH-1:0] req_addr [p_NUM_REQ];
  logic [p_LEN_WIDTH-1:0]  req_len  [p_NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < p_NUM_REQ; gi++) begin : g_unpack
      assign req_addr[gi] = i_ADDR[gi*p_ADDR_WIDTH +: p_ADDR_WIDTH];
      assign req_len[gi]  = i_LEN[gi*p_LEN_WIDTH +: p_LEN_WIDTH];
    end
  endgenerate

  rr_priority_picker #(
    .p_NUM_REQ  (p_NUM_REQ),
    .p_IDX_WIDTH(IW)
  ) u_picker (
    .req       (i_REQ),
    .ptr       (ptr_reg),
    .winner    (pick_onehot),
    .winner_idx(pick_idx),
    .found     (pick_found)
  );

  assign accept = (state_reg == S_IDLE) && pick_found;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (pick_found) state_next = S_BURST;
      S_BURST: if (cnt_reg == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_reg <= S_IDLE;
      ptr_reg   <= IW'(p_NUM_REQ - 1);
      owner_reg <= '0;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      valid_reg <= '0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      valid_reg <= '0;
      last_reg  <= 1'b0;
      if (accept) begin
        addr_reg  <= req_addr[pick_idx];
        cnt_reg   <= req_len[pick_idx];
        owner_reg <= pick_idx;
        ptr_reg   <= pick_idx;
      end
      // Return tags are registered so they line up with the ROM's 1-cycle data.
      if (state_reg == S_BURST) begin
        addr_reg  <= addr_reg + p_ADDR_WIDTH'(1);
        if (cnt_reg != '0) cnt_reg <= cnt_reg - p_LEN_WIDTH'(1);
        valid_reg <= p_NUM_REQ'(1) << owner_reg;
        last_reg  <= (cnt_reg == '0);
      end
    end
  end

  assign o_GRANT           = (accept && !i_RESET) ? pick_onehot : '0;
  assign o_ROM_READ_ENABLE = (state_reg == S_BURST);
  assign o_ROM_ADDRESS     = (state_reg == S_BURST) ? addr_reg : '0;
  assign o_VALID           = valid_reg;
  assign o_LAST            = last_reg;
  assign o_DATA            = (|valid_reg) ? i_ROM_DATA : '0;
  assign o_BUSY            = (state_reg == S_BURST) || (|valid_reg);

endmodule
